vld_realigner: RTL and testbench

- Upstream feeder of the vector load unit.
- Converts memory read beats into a VRF-word stream on the load-operand handshake of the load unit. Beats are DataWidthB wide and aligned to DataWidthB; the vector base address is unaligned.
- Removes the base-address byte offset with a byte funnel over the current and previous beat.
- Per instruction it emits exactly ceil(len/DataWidthB) words, then pulses done.

---
 rtl/core_pkg.sv | 27 ++
 rtl/byte_funnel.sv | 25 ++
 rtl/vld_realigner.sv | 184 ++++++++++++++++++
 tb/tb_vld_realigner.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared types and helpers for the vector load/store datapath.
//   insn_id_t           - instruction id carried through the load pipeline
//   vld_realign_state_e - realigner control states
//   GetBeatCnt()        - number of DataWidthB-sized blocks spanned by
//                         [off, off+len), rounded up
package core_pkg;

   typedef logic [7:0] insn_id_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRIME  = 2'd1,
      STREAM = 2'd2,
      TAIL   = 2'd3
   } vld_realign_state_e;

   // dw_log2 is log2 of the block size in bytes; callers truncate the result
   // to the width they need.
   function automatic logic [32:0] GetBeatCnt(input logic [31:0] off,
                                              input logic [31:0] len,
                                              input int unsigned dw_log2);
      logic [32:0] sum;
      sum = {1'b0, off} + {1'b0, len} + ((33'd1 << dw_log2) - 33'd1);
      return sum >> dw_log2;
   endfunction

endpackage

// File: rtl/byte_funnel.sv
// byte_funnel: combinational byte funnel over two adjacent words.
//   lo_i   - word at the lower address
//   hi_i   - word at the next higher address
//   off_i  - byte offset into lo_i of the first output byte
//   word_o - byte i = lo_i[i+off] if i+off < DataWidthB, else hi_i[i+off-DataWidthB]
module byte_funnel #(
   parameter int DataWidthB = 8
) (
   input  logic [8*DataWidthB-1:0]         lo_i,
   input  logic [8*DataWidthB-1:0]         hi_i,
   input  logic [$clog2(DataWidthB)-1:0]   off_i,
   output logic [8*DataWidthB-1:0]         word_o
);

   always_comb begin
      word_o = '0;
      for (int i = 0; i < DataWidthB; i++) begin
         if (i + int'(off_i) < DataWidthB)
            word_o[8*i +: 8] = lo_i[8*(i + int'(off_i)) +: 8];
         else
            word_o[8*i +: 8] = hi_i[8*(i + int'(off_i) - DataWidthB) +: 8];
      end
   end

endmodule

// File: rtl/vld_realigner.sv
// vld_realigner: turns DataWidthB-aligned memory read beats into a stream of
// VRF words starting at an unaligned base address, then pulses done.
// Ports:
//   clk_i, rst_i                         - clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o              - command handshake
//   cmd_offset_i, cmd_len_i, cmd_id_i    - base byte offset, byte length, id
//   beat_valid_i/beat_ready_o/beat_data_i - memory beat stream
//   load_op_valid_o/load_op_ready_i/load_op_o - realigned word stream
//   busy_o                               - a command is in flight
//   done_o, done_id_o                    - last-word pulse and its id
// Build option: VLD_REALIGNER_ZERO_TAIL_EN forces the bytes past the end of
// the data in the final word to zero; otherwise they are left as funnelled.
module vld_realigner
   import core_pkg::*;
#(
   parameter int DataWidthB = 8,
   parameter int LenWidth   = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          cmd_valid_i,
   output logic                          cmd_ready_o,
   input  logic [$clog2(DataWidthB)-1:0] cmd_offset_i,
   input  logic [LenWidth-1:0]           cmd_len_i,
   input  insn_id_t                      cmd_id_i,
   input  logic                          beat_valid_i,
   output logic                          beat_ready_o,
   input  logic [8*DataWidthB-1:0]       beat_data_i,
   output logic                          load_op_valid_o,
   input  logic                          load_op_ready_i,
   output logic [8*DataWidthB-1:0]       load_op_o,
   output logic                          busy_o,
   output logic                          done_o,
   output insn_id_t                      done_id_o
);

   localparam int OffW  = $clog2(DataWidthB);
   localparam int WordW = 8 * DataWidthB;

   vld_realign_state_e     state_q, state_d;
   logic [OffW-1:0]        off_q, off_d;
   insn_id_t               id_q, id_d;
   logic [LenWidth:0]      beats_left_q, beats_left_d;
   logic [LenWidth-1:0]    words_left_q, words_left_d;
   logic [WordW-1:0]       held_q, held_d;

   logic [LenWidth:0]      beats_cnt;
   logic [LenWidth-1:0]    words_cnt;
   logic [WordW-1:0]       funnel_hi;
   logic [WordW-1:0]       funnel_word;
   logic [WordW-1:0]       word_raw;
   logic                   beat_ready_raw;
   logic                   done_raw;

   assign beats_cnt = (LenWidth+1)'(GetBeatCnt(32'(cmd_offset_i), 32'(cmd_len_i), OffW));
   assign words_cnt = LenWidth'(GetBeatCnt(32'd0, 32'(cmd_len_i), OffW));

   // In TAIL there is no next beat; the funnel pulls zeros past the held word.
   assign funnel_hi = (state_q == TAIL) ? '0 : beat_data_i;

   byte_funnel #(
      .DataWidthB (DataWidthB)
   ) u_funnel (
      .lo_i   (held_q),
      .hi_i   (funnel_hi),
      .off_i  (off_q),
      .word_o (funnel_word)
   );

   always_comb begin
      state_d         = state_q;
      off_d           = off_q;
      id_d            = id_q;
      beats_left_d    = beats_left_q;
      words_left_d    = words_left_q;
      held_d          = held_q;
      cmd_ready_o     = 1'b0;
      beat_ready_raw  = 1'b0;
      load_op_valid_o = 1'b0;
      word_raw        = funnel_word;
      done_raw        = 1'b0;

      unique case (state_q)
         IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) begin
               off_d        = cmd_offset_i;
               id_d         = cmd_id_i;
               beats_left_d = beats_cnt;
               words_left_d = words_cnt;
               if (cmd_len_i == '0)
                  done_raw = 1'b1;
               else if (cmd_offset_i != '0)
                  state_d = PRIME;
               else
                  state_d = STREAM;
            end
         end
         PRIME: begin
            beat_ready_raw = 1'b1;
            if (beat_valid_i) begin
               held_d       = beat_data_i;
               beats_left_d = beats_left_q - 1'b1;
               state_d      = (beats_left_q == 1) ? TAIL : STREAM;
            end
         end
         STREAM: begin
            // Valid follows the beat only; ready is passed straight upstream.
            load_op_valid_o = beat_valid_i;
            beat_ready_raw  = load_op_ready_i;
            word_raw        = (off_q == '0) ? beat_data_i : funnel_word;
            if (beat_valid_i && load_op_ready_i) begin
               held_d       = beat_data_i;
               beats_left_d = beats_left_q - 1'b1;
               words_left_d = words_left_q - 1'b1;
               if (words_left_q == 1) begin
                  done_raw = 1'b1;
                  state_d  = IDLE;
               end else if (beats_left_q == 1) begin
                  state_d = TAIL;
               end
            end
         end
         TAIL: begin
            load_op_valid_o = 1'b1;
            if (load_op_ready_i) begin
               done_raw = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A reset landing mid-command must neither consume a beat nor signal done.
   assign beat_ready_o = beat_ready_raw & ~rst_i;
   assign done_o       = done_raw & ~rst_i;
   assign busy_o       = (state_q != IDLE);
   // Zero-length commands finish in their accept cycle, before id is latched.
   assign done_id_o    = (state_q == IDLE) ? cmd_id_i : id_q;

`ifdef VLD_REALIGNER_ZERO_TAIL_EN
   logic [OffW-1:0] tail_mod_q, tail_mod_d;
   logic            last_word;

   assign tail_mod_d = (state_q == IDLE && cmd_valid_i) ? cmd_len_i[OffW-1:0] : tail_mod_q;
   assign last_word  = (state_q == TAIL) || (state_q == STREAM && words_left_q == 1);

   always_ff @(posedge clk_i) begin
      if (rst_i) tail_mod_q <= '0;
      else       tail_mod_q <= tail_mod_d;
   end

   always_comb begin
      load_op_o = word_raw;
      if (last_word && tail_mod_q != '0) begin
         for (int i = 0; i < DataWidthB; i++) begin
            if (i >= int'(tail_mod_q)) load_op_o[8*i +: 8] = 8'h00;
         end
      end
   end
`else
   assign load_op_o = word_raw;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         off_q        <= '0;
         id_q         <= '0;
         beats_left_q <= '0;
         words_left_q <= '0;
         held_q       <= '0;
      end else begin
         state_q      <= state_d;
         off_q        <= off_d;
         id_q         <= id_d;
         beats_left_q <= beats_left_d;
         words_left_q <= words_left_d;
         held_q       <= held_d;
      end
   end

endmodule

// File: tb/tb_vld_realigner.sv
// tb_vld_realigner: directed bench for vld_realigner with DataWidthB=8.
// Each command restarts the beat source at beat 0; beat n byte i = 8n+i.
module tb_vld_realigner;
   import core_pkg::*;

   logic           clk_i = 1'b0;
   logic           rst_i;
   logic           cmd_valid_i;
   logic           cmd_ready_o;
   logic [2:0]     cmd_offset_i;
   logic [15:0]    cmd_len_i;
   insn_id_t       cmd_id_i;
   logic           beat_valid_i;
   logic           beat_ready_o;
   logic [63:0]    beat_data_i;
   logic           load_op_valid_o;
   logic           load_op_ready_i;
   logic [63:0]    load_op_o;
   logic           busy_o;
   logic           done_o;
   insn_id_t       done_id_o;

   int nvec = 0;
   int nmis = 0;
   int bidx = 0;
   int nbeats = 0;

   always #5 clk_i = ~clk_i;

   vld_realigner #(
      .DataWidthB (8),
      .LenWidth   (16)
   ) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .cmd_valid_i     (cmd_valid_i),
      .cmd_ready_o     (cmd_ready_o),
      .cmd_offset_i    (cmd_offset_i),
      .cmd_len_i       (cmd_len_i),
      .cmd_id_i        (cmd_id_i),
      .beat_valid_i    (beat_valid_i),
      .beat_ready_o    (beat_ready_o),
      .beat_data_i     (beat_data_i),
      .load_op_valid_o (load_op_valid_o),
      .load_op_ready_i (load_op_ready_i),
      .load_op_o       (load_op_o),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .done_id_o       (done_id_o)
   );

   function automatic logic [63:0] mkbeat(input int n);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = 8'(8*n + i);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nmis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock, crediting a beat if one was handed over this cycle.
   task automatic step();
      if (beat_valid_i && beat_ready_o) begin
         nbeats++;
         bidx++;
      end
      @(posedge clk_i);
      #1;
      beat_data_i = mkbeat(bidx);
      #1;
   endtask

   task automatic new_cmd(input logic [2:0] off, input logic [15:0] len, input insn_id_t id);
      bidx         = 0;
      nbeats       = 0;
      beat_data_i  = mkbeat(0);
      beat_valid_i = 1'b1;
      cmd_valid_i  = 1'b1;
      cmd_offset_i = off;
      cmd_len_i    = len;
      cmd_id_i     = id;
      #1;
      chk("cmd_ready", 64'(cmd_ready_o), 64'd1);
      step();
      cmd_valid_i = 1'b0;
      #1;
   endtask

   initial begin
      rst_i           = 1'b1;
      cmd_valid_i     = 1'b0;
      cmd_offset_i    = '0;
      cmd_len_i       = '0;
      cmd_id_i        = '0;
      beat_valid_i    = 1'b0;
      beat_data_i     = '0;
      load_op_ready_i = 1'b1;
      @(posedge clk_i);
      @(posedge clk_i);
      #2;
      chk("rst_busy",      64'(busy_o),          64'd0);
      chk("rst_cmd_ready", 64'(cmd_ready_o),     64'd1);
      chk("rst_valid",     64'(load_op_valid_o), 64'd0);
      chk("rst_bready",    64'(beat_ready_o),    64'd0);
      chk("rst_done",      64'(done_o),          64'd0);
      rst_i = 1'b0;
      step();

      // off=0 len=16: words are the beats themselves, one per cycle.
      new_cmd(3'd0, 16'd16, 8'd1);
      chk("t1_w0_valid", 64'(load_op_valid_o), 64'd1);
      chk("t1_w0_bready", 64'(beat_ready_o), 64'd1);
      chk("t1_w0_data", load_op_o, 64'h0706050403020100);
      chk("t1_w0_done", 64'(done_o), 64'd0);
      step();
      chk("t1_w1_data", load_op_o, 64'h0F0E0D0C0B0A0908);
      chk("t1_w1_done", 64'(done_o), 64'd1);
      chk("t1_w1_id", 64'(done_id_o), 64'd1);
      step();
      chk("t1_idle_busy", 64'(busy_o), 64'd0);
      chk("t1_idle_valid", 64'(load_op_valid_o), 64'd0);
      chk("t1_beats", 64'(nbeats), 64'd2);

      // off=3 len=8: prime, then one funnelled word.
      new_cmd(3'd3, 16'd8, 8'd2);
      chk("t2_prime_valid", 64'(load_op_valid_o), 64'd0);
      chk("t2_prime_bready", 64'(beat_ready_o), 64'd1);
      step();
      chk("t2_w0_data", load_op_o, 64'h0A09080706050403);
      chk("t2_w0_done", 64'(done_o), 64'd1);
      chk("t2_w0_id", 64'(done_id_o), 64'd2);
      step();
      chk("t2_beats", 64'(nbeats), 64'd2);
      chk("t2_busy", 64'(busy_o), 64'd0);

      // off=2 len=4: prime, then a tail word with no beat.
      new_cmd(3'd2, 16'd4, 8'd3);
      chk("t3_prime_bready", 64'(beat_ready_o), 64'd1);
      step();
      chk("t3_tail_valid", 64'(load_op_valid_o), 64'd1);
      chk("t3_tail_bready", 64'(beat_ready_o), 64'd0);
`ifdef VLD_REALIGNER_ZERO_TAIL_EN
      chk("t3_tail_data", load_op_o, 64'h0000000005040302);
`else
      chk("t3_tail_data", load_op_o, 64'h0000070605040302);
`endif
      chk("t3_tail_done", 64'(done_o), 64'd1);
      step();
      chk("t3_beats", 64'(nbeats), 64'd1);

      // off=2 len=12: stream one word, then tail.
      new_cmd(3'd2, 16'd12, 8'd4);
      step();
      chk("t4_w0_data", load_op_o, 64'h0908070605040302);
      chk("t4_w0_done", 64'(done_o), 64'd0);
      step();
      chk("t4_w1_bready", 64'(beat_ready_o), 64'd0);
`ifdef VLD_REALIGNER_ZERO_TAIL_EN
      chk("t4_w1_data", load_op_o, 64'h000000000D0C0B0A);
`else
      chk("t4_w1_data", load_op_o, 64'h00000F0E0D0C0B0A);
`endif
      chk("t4_w1_done", 64'(done_o), 64'd1);
      chk("t4_w1_id", 64'(done_id_o), 64'd4);
      step();
      chk("t4_beats", 64'(nbeats), 64'd2);

      // off=5 len=24 with downstream ready toggling 1010.
      new_cmd(3'd5, 16'd24, 8'd5);
      step();
      load_op_ready_i = 1'b1; #1;
      chk("t5_w0_bready", 64'(beat_ready_o), 64'd1);
      chk("t5_w0_data", load_op_o, 64'h0C0B0A0908070605);
      step();
      load_op_ready_i = 1'b0; #1;
      chk("t5_stall1_valid", 64'(load_op_valid_o), 64'd1);
      chk("t5_stall1_bready", 64'(beat_ready_o), 64'd0);
      chk("t5_stall1_data", load_op_o, 64'h14131211100F0E0D);
      step();
      load_op_ready_i = 1'b1; #1;
      chk("t5_w1_data", load_op_o, 64'h14131211100F0E0D);
      chk("t5_w1_done", 64'(done_o), 64'd0);
      step();
      load_op_ready_i = 1'b0; #1;
      chk("t5_stall2_bready", 64'(beat_ready_o), 64'd0);
      chk("t5_stall2_done", 64'(done_o), 64'd0);
      chk("t5_stall2_data", load_op_o, 64'h1C1B1A1918171615);
      step();
      load_op_ready_i = 1'b1; #1;
      chk("t5_w2_data", load_op_o, 64'h1C1B1A1918171615);
      chk("t5_w2_done", 64'(done_o), 64'd1);
      step();
      chk("t5_beats", 64'(nbeats), 64'd4);

      // len=0: done in the command cycle, no beats taken.
      bidx = 0; nbeats = 0; beat_data_i = mkbeat(0);
      cmd_valid_i = 1'b1; cmd_offset_i = 3'd1; cmd_len_i = 16'd0; cmd_id_i = 8'd6;
      #1;
      chk("t6_done", 64'(done_o), 64'd1);
      chk("t6_id", 64'(done_id_o), 64'd6);
      step();
      cmd_valid_i = 1'b0; #1;
      chk("t6_busy", 64'(busy_o), 64'd0);
      chk("t6_bready", 64'(beat_ready_o), 64'd0);
      step();
      chk("t6_beats", 64'(nbeats), 64'd0);

      // Reset in the middle of a STREAM command.
      new_cmd(3'd0, 16'd32, 8'd7);
      chk("t7_stream_valid", 64'(load_op_valid_o), 64'd1);
      step();
      rst_i = 1'b1; #1;
      chk("t7_rst_done", 64'(done_o), 64'd0);
      chk("t7_rst_bready", 64'(beat_ready_o), 64'd0);
      step();
      rst_i = 1'b0; #1;
      chk("t7_post_busy", 64'(busy_o), 64'd0);
      chk("t7_post_cmd_ready", 64'(cmd_ready_o), 64'd1);
      chk("t7_post_valid", 64'(load_op_valid_o), 64'd0);
      chk("t7_post_bready", 64'(beat_ready_o), 64'd0);
      chk("t7_post_done", 64'(done_o), 64'd0);
      step();
      chk("t7_beats", 64'(nbeats), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
